// File: rtl/pu_read_buffer.sv
// PU buffer-read responder: packs 16-bit operands into wide words, queues them in a FIFO, serves pop requests.
// Optional sticky underflow flag output rd_underflow when PU_BUF_UNDERFLOW_EN is defined.
module pu_read_buffer #(
  parameter int OP_WIDTH   = 16,
  parameter int NUM_OPS    = 4,
  parameter int DATA_WIDTH = OP_WIDTH * NUM_OPS,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  wr_valid,
  input  logic [OP_WIDTH-1:0]   wr_data,
  input  logic                  wr_last,
  output logic                  wr_ready,
  input  logic                  buffer_read_req,
  output logic                  buffer_read_data_valid,
  output logic [DATA_WIDTH-1:0] buffer_read_data_out,
  output logic                  buffer_read_empty,
  output logic                  buffer_read_last,
  output logic [ADDR_WIDTH:0]   buffer_count
`ifdef PU_BUF_UNDERFLOW_EN
  ,
  output logic                  rd_underflow
`endif
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int CNT_W = (NUM_OPS > 1) ? $clog2(NUM_OPS) : 1;
  localparam logic [CNT_W-1:0]    LAST_LANE  = CNT_W'(NUM_OPS - 1);
  localparam logic [ADDR_WIDTH:0] FULL_COUNT = (ADDR_WIDTH + 1)'(DEPTH);

  typedef enum logic {
    PACK_IDLE,
    PACKING
  } pack_state_t;

  pack_state_t           r_pack_state;
  pack_state_t           w_pack_state_next;
  logic [CNT_W-1:0]      r_pack_cnt;
  logic [CNT_W-1:0]      w_pack_cnt_next;
  logic [DATA_WIDTH-1:0] r_partial;
  logic [DATA_WIDTH-1:0] w_partial_next;
  logic [DATA_WIDTH-1:0] w_push_word;

  logic w_accept;
  logic w_push;
  logic w_pop;

  logic [DATA_WIDTH:0]   r_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [ADDR_WIDTH:0]   r_count;

  logic                  r_valid;
  logic                  r_last;
  logic [DATA_WIDTH-1:0] r_data_out;

  // Flow control looks only at the registered count; a same-cycle pop earns no credit.
  assign wr_ready          = (r_count != FULL_COUNT);
  assign buffer_read_empty = (r_count == '0);
  assign w_accept          = wr_valid & wr_ready & ~flush;
  assign w_push            = w_accept & ((r_pack_cnt == LAST_LANE) | wr_last);
  assign w_pop             = buffer_read_req & ~buffer_read_empty & ~flush;

  assign buffer_read_data_valid = r_valid;
  assign buffer_read_data_out   = r_data_out;
  assign buffer_read_last       = r_last;
  assign buffer_count           = r_count;

  // The partial word is kept zero above the fill point, so unfilled lanes of a pushed word are already zero.
  always_comb begin
    w_push_word = r_partial;
    for (int i = 0; i < NUM_OPS; i++) begin
      if (r_pack_cnt == CNT_W'(i)) begin
        w_push_word[i*OP_WIDTH +: OP_WIDTH] = wr_data;
      end
    end
  end

  always_comb begin
    w_pack_state_next = r_pack_state;
    w_pack_cnt_next   = r_pack_cnt;
    w_partial_next    = r_partial;
    if (flush || w_push) begin
      w_pack_state_next = PACK_IDLE;
      w_pack_cnt_next   = '0;
      w_partial_next    = '0;
    end else if (w_accept) begin
      w_pack_state_next = PACKING;
      w_partial_next    = w_push_word;
      w_pack_cnt_next   = (r_pack_state == PACK_IDLE) ? CNT_W'(1) : r_pack_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pack_state <= PACK_IDLE;
      r_pack_cnt   <= '0;
      r_partial    <= '0;
    end else begin
      r_pack_state <= w_pack_state_next;
      r_pack_cnt   <= w_pack_cnt_next;
      r_partial    <= w_partial_next;
    end
  end

  // Storage carries no reset; only pointers and count define which entries are live.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {wr_last, w_push_word};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + ADDR_WIDTH'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + ADDR_WIDTH'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (ADDR_WIDTH + 1)'(1);
        2'b01:   r_count <= r_count - (ADDR_WIDTH + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Data and last hold their values between pops, including across a flush.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid    <= 1'b0;
      r_last     <= 1'b0;
      r_data_out <= '0;
    end else begin
      r_valid <= w_pop;
      if (w_pop) begin
        {r_last, r_data_out} <= r_mem[r_rd_ptr];
      end
    end
  end

`ifdef PU_BUF_UNDERFLOW_EN
  logic r_underflow;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_underflow <= 1'b0;
    end else if (flush) begin
      r_underflow <= 1'b0;
    end else if (buffer_read_req && buffer_read_empty) begin
      r_underflow <= 1'b1;
    end
  end

  assign rd_underflow = r_underflow;
`else
  // Requests against an empty buffer are silently ignored.
`endif

endmodule
